// File: rtl/gate_truth_checker_if.sv
// Bus bundle for gate_truth_checker: sweep control, expected table,
// stimulus/response to the gate under test and the sweep results.
// The slave modport is the checker itself; the master modport is whoever
// requests sweeps and closes the loop through the gate under test.
interface gate_truth_checker_if #(
    parameter int N_IN = 1
);
    localparam int V = 1 << N_IN;

    logic            start;
    logic [V-1:0]    exp_tt;
    logic [N_IN-1:0] stim;
    logic            resp;
    logic            busy;
    logic            done;
    logic            pass;
    logic [V-1:0]    tt_out;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_err_idx;

    modport master (
        output start, exp_tt, resp,
        input  stim, busy, done, pass, tt_out, err_cnt, first_err_idx
    );

    modport slave (
        input  start, exp_tt, resp,
        output stim, busy, done, pass, tt_out, err_cnt, first_err_idx
    );
endinterface

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps every input vector of a single-output gate,
// waits SETTLE cycles per vector, samples the gate output, builds the
// measured truth table and compares it against a latched expected table.
// Optional feature macro: STOP_ON_ERR_EN -- when defined, the sweep ends
// at the first mismatching vector instead of running to completion.
// The interface instance must be built with the same N_IN as this module.
module gate_truth_checker #(
    parameter int N_IN   = 1,
    parameter int SETTLE = 2,
    parameter int CW     = 3
) (
    input logic                 clk,
    input logic                 rst,
    gate_truth_checker_if.slave bus
);
    localparam int V = 1 << N_IN;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t          state_q;
    logic [V-1:0]    expTt_q;
    logic [V-1:0]    ttOut_q;
    logic [N_IN:0]   errCnt_q;
    logic [N_IN-1:0] firstErr_q;
    logic [N_IN-1:0] index_q;
    logic [N_IN-1:0] stim_q;
    logic [CW-1:0]   settleCnt_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;

    logic            mismatch;
    logic [N_IN:0]   errCnt_d;
    logic            lastVec;
    logic            sweepEnd;

    // Compare the sampled response with the latched expectation and work out
    // whether this sample is the final one of the sweep.
    always_comb begin
        mismatch = (bus.resp != expTt_q[index_q]);
        errCnt_d = errCnt_q + (N_IN + 1)'(mismatch);
        lastVec  = (index_q == N_IN'(V - 1));
`ifdef STOP_ON_ERR_EN
        sweepEnd = lastVec || mismatch;
`else
        sweepEnd = lastVec;
`endif
    end

    // Sweep controller: all state and outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            expTt_q     <= '0;
            ttOut_q     <= '0;
            errCnt_q    <= '0;
            firstErr_q  <= '0;
            index_q     <= '0;
            stim_q      <= '0;
            settleCnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        expTt_q     <= bus.exp_tt;
                        ttOut_q     <= '0;
                        errCnt_q    <= '0;
                        firstErr_q  <= '0;
                        pass_q      <= 1'b0;
                        index_q     <= '0;
                        stim_q      <= '0;
                        settleCnt_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settleCnt_q == CW'(SETTLE - 1)) begin
                        settleCnt_q <= '0;
                        state_q     <= SAMPLE;
                    end else begin
                        settleCnt_q <= settleCnt_q + CW'(1);
                    end
                end
                SAMPLE: begin
                    ttOut_q[index_q] <= bus.resp;
                    errCnt_q         <= errCnt_d;
                    if (mismatch && (errCnt_q == '0)) begin
                        firstErr_q <= index_q;
                    end
                    if (sweepEnd) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (errCnt_d == '0);
                        state_q <= DONE;
                    end else begin
                        index_q <= index_q + N_IN'(1);
                        stim_q  <= index_q + N_IN'(1);
                        state_q <= DRIVE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.stim          = stim_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.tt_out        = ttOut_q;
    assign bus.err_cnt       = errCnt_q;
    assign bus.first_err_idx = firstErr_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Testbench for gate_truth_checker: a 2-input instance driven by a
// programmable gate table with directed and random sweeps, plus a
// 1-input instance wired as a NOT gate.
module tb_gate_truth_checker;

    logic clk;
    logic rst;
    logic [3:0] gateTbl;

    int compared;
    int mismatched;

    gate_truth_checker_if #(.N_IN(2)) gif ();
    gate_truth_checker_if #(.N_IN(1)) gif1 ();

    gate_truth_checker #(.N_IN(2), .SETTLE(2), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (gif)
    );

    gate_truth_checker #(.N_IN(1), .SETTLE(2), .CW(3)) dutNot (
        .clk (clk),
        .rst (rst),
        .bus (gif1)
    );

    // Gate under test models: arbitrary 2-input table and a NOT gate.
    assign gif.resp  = gateTbl[gif.stim];
    assign gif1.resp = ~gif1.stim[0];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: what a sweep of gate table g against expected e reports.
    function automatic void sweepModel(input logic [3:0] g, input logic [3:0] e,
                                       output logic [3:0] tt, output int err,
                                       output int first, output int lat,
                                       output bit ps, output int lastStim);
        err = 0;
        first = 0;
        tt = g;
        for (int i = 0; i < 4; i++) begin
            if (g[i] != e[i]) begin
                if (err == 0) first = i;
                err++;
            end
        end
        lat = 4 * 3;
        lastStim = 3;
`ifdef STOP_ON_ERR_EN
        if (err > 0) begin
            err = 1;
            for (int i = 0; i < 4; i++) begin
                if (i > first) tt[i] = 1'b0;
            end
            lat = (first + 1) * 3;
            lastStim = first;
        end
`endif
        ps = (err == 0);
    endfunction

    task automatic applyStimulus(input logic [3:0] g, input logic [3:0] e,
                                 input bit disturb, input bit startInDone);
        logic [3:0] mTt;
        int mErr, mFirst, mLat, mLast, cyc;
        bit mPass;
        sweepModel(g, e, mTt, mErr, mFirst, mLat, mPass, mLast);
        gateTbl = g;
        @(negedge clk);
        gif.exp_tt = e;
        gif.start = 1'b1;
        @(posedge clk);
        #1;
        gif.start = 1'b0;
        checkOutput("busyRise", gif.busy, 1);
        checkOutput("clrTt", gif.tt_out, 0);
        checkOutput("clrErr", gif.err_cnt, 0);
        checkOutput("clrPass", gif.pass, 0);
        cyc = 0;
        while (!gif.done && cyc < 60) begin
            if (cyc < mLat) begin
                checkOutput("stimStep", gif.stim, cyc / 3);
                checkOutput("busyHeld", gif.busy, 1);
            end
            if (disturb && cyc == 2) begin
                gif.start = 1'b1;
                gif.exp_tt = ~e;
            end
            if (cyc == 3) gif.start = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        gif.start = 1'b0;
        checkOutput("latency", cyc, mLat);
        checkOutput("ttOut", gif.tt_out, mTt);
        checkOutput("errCnt", gif.err_cnt, mErr);
        if (mErr != 0) checkOutput("firstErr", gif.first_err_idx, mFirst);
        checkOutput("pass", gif.pass, mPass);
        checkOutput("busyDone", gif.busy, 0);
        if (startInDone) gif.start = 1'b1;
        @(posedge clk);
        #1;
        gif.start = 1'b0;
        checkOutput("donePulse", gif.done, 0);
        checkOutput("busyIdle", gif.busy, 0);
        checkOutput("stimHold", gif.stim, mLast);
        checkOutput("ttHold", gif.tt_out, mTt);
    endtask

    initial begin
        int cyc, doneSeen;
        logic [3:0] g, e;
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        gateTbl = 4'b0000;
        gif.start = 1'b0;
        gif.exp_tt = '0;
        gif1.start = 1'b0;
        gif1.exp_tt = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstStim", gif.stim, 0);
        checkOutput("rstBusy", gif.busy, 0);
        checkOutput("rstDone", gif.done, 0);
        checkOutput("rstPass", gif.pass, 0);
        checkOutput("rstTt", gif.tt_out, 0);
        checkOutput("rstErr", gif.err_cnt, 0);
        checkOutput("rstFirst", gif.first_err_idx, 0);
        @(negedge clk);
        rst = 1'b0;

        // NOT gate on the 1-input instance.
        @(negedge clk);
        gif1.exp_tt = 2'b01;
        gif1.start = 1'b1;
        @(posedge clk);
        #1;
        gif1.start = 1'b0;
        checkOutput("notBusy", gif1.busy, 1);
        cyc = 0;
        while (!gif1.done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("notLatency", cyc, 6);
        checkOutput("notTt", gif1.tt_out, 2'b01);
        checkOutput("notErr", gif1.err_cnt, 0);
        checkOutput("notPass", gif1.pass, 1);
        @(posedge clk);
        #1;

        // Directed sweeps: AND2, stuck-at-0 vs XOR, start while busy, start in DONE.
        applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0110, 1'b0, 1'b0);
        applyStimulus(4'b0110, 4'b0111, 1'b1, 1'b0);
        applyStimulus(4'b1110, 4'b1110, 1'b0, 1'b1);

        // Back-to-back: the second start lands in the cycle after done.
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0110, 4'b0110, 1'b0, 1'b0);

        // Reset during the DRIVE phase of vector 1.
        gateTbl = 4'b1111;
        @(negedge clk);
        gif.exp_tt = 4'b0000;
        gif.start = 1'b1;
        @(posedge clk);
        #1;
        gif.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("preRstStim", gif.stim, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstStim", gif.stim, 0);
        checkOutput("midRstBusy", gif.busy, 0);
        checkOutput("midRstDone", gif.done, 0);
        checkOutput("midRstPass", gif.pass, 0);
        checkOutput("midRstTt", gif.tt_out, 0);
        checkOutput("midRstErr", gif.err_cnt, 0);
        checkOutput("midRstFirst", gif.first_err_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (gif.done) doneSeen++;
        end
        checkOutput("noDoneAfterRst", doneSeen, 0);
        applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b0);

        // Random gates and expectations.
        for (int n = 0; n < 20; n++) begin
            g = 4'($urandom);
            e = ($urandom_range(0, 1) == 1) ? g : 4'($urandom);
            applyStimulus(g, e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
